// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB inputs, the two ID read ports and the retire record.
// master = the pipeline side driving MEM/WB values and read indices; slave = the register file.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [1:0]        WB;             // [1] RegWrite, [0] MemtoReg
  logic [DATA_W-1:0] WB_Address;
  logic [DATA_W-1:0] WB_Data;
  logic [ADDR_W-1:0] Write_Register;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              ret_valid;
  logic [ADDR_W-1:0] ret_reg;
  logic [DATA_W-1:0] ret_value;
  logic [31:0]       ret_count;

  modport master (
    output WB, WB_Address, WB_Data, Write_Register, rs_addr, rt_addr,
    input  rs_data, rt_data, ret_valid, ret_reg, ret_value, ret_count
  );

  modport slave (
    input  WB, WB_Address, WB_Data, Write_Register, rs_addr, rt_addr,
    output rs_data, rt_data, ret_valid, ret_reg, ret_value, ret_count
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// Write-back stage and architectural register file.
// Selects ALU result or load data, commits it to the register file (r0 hardwired to zero),
// serves two combinational read ports and publishes a registered retire record plus counter.
// Optional: define WB_BYPASS_EN for write-through bypass of the value committing this cycle.
module wb_regfile_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  if ((1 << ADDR_W) != REG_N) begin : g_bad_params
    $error("wb_regfile_stage: 2**ADDR_W must equal REG_N");
  end

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic              ret_valid_q, ret_valid_d;
  logic [ADDR_W-1:0] ret_reg_q, ret_reg_d;
  logic [DATA_W-1:0] ret_value_q, ret_value_d;
  logic [31:0]       ret_count_q, ret_count_d;

  logic [DATA_W-1:0] wb_value;
  logic              commit;

  // Write-back value select and commit qualification (writes to r0 are dropped).
  always_comb begin
    wb_value = bus.WB[0] ? bus.WB_Data : bus.WB_Address;
    commit   = bus.WB[1] && (bus.Write_Register != '0);
  end

  // Next-state for the array and the retire record.
  always_comb begin
    regs_d      = regs_q;
    ret_valid_d = 1'b0;
    ret_reg_d   = ret_reg_q;
    ret_value_d = ret_value_q;
    ret_count_d = ret_count_q;
    if (commit) begin
      regs_d[bus.Write_Register] = wb_value;
      ret_valid_d                = 1'b1;
      ret_reg_d                  = bus.Write_Register;
      ret_value_d                = wb_value;
      ret_count_d                = ret_count_q + 32'd1;  // wraps silently
    end
  end

  // State registers; synchronous reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        regs_q[i] <= '0;
      end
      ret_valid_q <= 1'b0;
      ret_reg_q   <= '0;
      ret_value_q <= '0;
      ret_count_q <= '0;
    end else begin
      regs_q      <= regs_d;
      ret_valid_q <= ret_valid_d;
      ret_reg_q   <= ret_reg_d;
      ret_value_q <= ret_value_d;
      ret_count_q <= ret_count_d;
    end
  end

  // Read ports: index 0 always reads zero; optional same-cycle bypass of the committing value.
  always_comb begin
    bus.rs_data = (bus.rs_addr == '0) ? '0 : regs_q[bus.rs_addr];
    bus.rt_data = (bus.rt_addr == '0) ? '0 : regs_q[bus.rt_addr];
`ifdef WB_BYPASS_EN
    // commit already excludes r0, so a match implies a nonzero index.
    if (commit && (bus.rs_addr == bus.Write_Register)) bus.rs_data = wb_value;
    if (commit && (bus.rt_addr == bus.Write_Register)) bus.rt_data = wb_value;
`endif
  end

  // Retire record outputs.
  always_comb begin
    bus.ret_valid = ret_valid_q;
    bus.ret_reg   = ret_reg_q;
    bus.ret_value = ret_value_q;
    bus.ret_count = ret_count_q;
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: reset, ALU/load write-back, r0 and no-write,
// same-cycle read (both build flavours) and retire counter wrap.
module tb_wb_regfile_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile_stage #(.DATA_W(32), .REG_N(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One write-back transaction: drive at negedge, clock it in, return to a bubble at next negedge.
  task automatic wb_txn(input logic [1:0] wb, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wreg);
    @(negedge clk);
    bus.WB             = wb;
    bus.WB_Address     = addr;
    bus.WB_Data        = data;
    bus.Write_Register = wreg;
    @(posedge clk);
    @(negedge clk);
    bus.WB = 2'b00;
  endtask

  initial begin
    bus.WB             = 2'b00;
    bus.WB_Address     = '0;
    bus.WB_Data        = '0;
    bus.Write_Register = '0;
    bus.rs_addr        = '0;
    bus.rt_addr        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset clear: preload r5, then reset alongside a commit to r7.
    wb_txn(2'b10, 32'h0000_1234, 32'h0, 5'd5);
    bus.rs_addr = 5'd5;
    #1 check_eq("preload_r5", bus.rs_data, 32'h0000_1234);
    bus.WB             = 2'b10;
    bus.WB_Address     = 32'h0000_0BAD;
    bus.Write_Register = 5'd7;
    rst                = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    bus.WB = 2'b00;
    check_eq("rst_ret_valid", {31'd0, bus.ret_valid}, 32'd0);
    check_eq("rst_ret_reg", {27'd0, bus.ret_reg}, 32'd0);
    check_eq("rst_ret_value", bus.ret_value, 32'd0);
    check_eq("rst_ret_count", bus.ret_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      check_eq($sformatf("rst_rs_r%0d", i), bus.rs_data, 32'd0);
      check_eq($sformatf("rst_rt_r%0d", 31 - i), bus.rt_data, 32'd0);
    end

    // ALU write-back.
    wb_txn(2'b10, 32'hDEAD_BEEF, 32'h1111_1111, 5'd3);
    bus.rs_addr = 5'd3;
    #1;
    check_eq("alu_rs_r3", bus.rs_data, 32'hDEAD_BEEF);
    check_eq("alu_ret_valid", {31'd0, bus.ret_valid}, 32'd1);
    check_eq("alu_ret_reg", {27'd0, bus.ret_reg}, 32'd3);
    check_eq("alu_ret_value", bus.ret_value, 32'hDEAD_BEEF);
    check_eq("alu_ret_count", bus.ret_count, 32'd1);

    // Load write-back.
    wb_txn(2'b11, 32'h0000_0040, 32'h0000_00A5, 5'd31);
    bus.rt_addr = 5'd31;
    #1;
    check_eq("load_rt_r31", bus.rt_data, 32'h0000_00A5);
    check_eq("load_ret_value", bus.ret_value, 32'h0000_00A5);
    check_eq("load_ret_count", bus.ret_count, 32'd2);

    // Register 0 and no-write.
    wb_txn(2'b10, 32'h0000_0044, 32'h0, 5'd4);
    check_eq("pre_r4_count", bus.ret_count, 32'd3);
    wb_txn(2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0);
    bus.rs_addr = 5'd0;
    #1;
    check_eq("r0_rs", bus.rs_data, 32'd0);
    check_eq("r0_ret_valid", {31'd0, bus.ret_valid}, 32'd0);
    check_eq("r0_ret_count", bus.ret_count, 32'd3);
    wb_txn(2'b01, 32'h0000_0888, 32'h0000_0999, 5'd4);
    bus.rt_addr = 5'd4;
    #1;
    check_eq("nowr_r4", bus.rt_data, 32'h0000_0044);
    check_eq("nowr_ret_valid", {31'd0, bus.ret_valid}, 32'd0);
    check_eq("nowr_ret_count", bus.ret_count, 32'd3);
    check_eq("nowr_ret_reg_hold", {27'd0, bus.ret_reg}, 32'd4);
    check_eq("nowr_ret_value_hold", bus.ret_value, 32'h0000_0044);

    // Same-cycle read of the register being committed.
    wb_txn(2'b10, 32'h0000_0001, 32'h0, 5'd9);
    @(negedge clk);
    bus.WB             = 2'b10;
    bus.WB_Address     = 32'h0000_0077;
    bus.WB_Data        = 32'h0000_5555;
    bus.Write_Register = 5'd9;
    bus.rs_addr        = 5'd9;
    bus.rt_addr        = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("same_rs", bus.rs_data, 32'h0000_0077);
    check_eq("same_rt", bus.rt_data, 32'h0000_0077);
`else
    check_eq("same_rs", bus.rs_data, 32'h0000_0001);
    check_eq("same_rt", bus.rt_data, 32'h0000_0001);
`endif
    @(posedge clk);
    @(negedge clk);
    bus.WB = 2'b00;
    #1;
    check_eq("after_rs", bus.rs_data, 32'h0000_0077);
    check_eq("after_rt", bus.rt_data, 32'h0000_0077);
    check_eq("after_count", bus.ret_count, 32'd5);

    // Counter wrap: preset the counter through its next-state during an idle edge.
    @(negedge clk);
    force dut.ret_count_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.ret_count_d;
    @(negedge clk);
    check_eq("wrap_preset", bus.ret_count, 32'hFFFF_FFFE);
    wb_txn(2'b10, 32'h0000_0A0A, 32'h0, 5'd10);
    check_eq("wrap_1", bus.ret_count, 32'hFFFF_FFFF);
    wb_txn(2'b11, 32'h0, 32'h0000_0B0B, 5'd11);
    check_eq("wrap_2", bus.ret_count, 32'h0000_0000);
    wb_txn(2'b10, 32'h0000_0C0C, 32'h0, 5'd12);
    check_eq("wrap_3", bus.ret_count, 32'h0000_0001);
    bus.rs_addr = 5'd11;
    bus.rt_addr = 5'd12;
    #1;
    check_eq("wrap_r11", bus.rs_data, 32'h0000_0B0B);
    check_eq("wrap_r12", bus.rt_data, 32'h0000_0C0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
